ps_pad_poll_scheduler: RTL
==========================

// Module: ps_pad_poll_scheduler
// PURPOSE
// Sequences polling of two DualShock pads that share one SPI byte engine (the engine moves one
// byte full-duplex per start/done handshake). Owns both active-low selects, alternates pads each
// poll slot, decodes reply length from the ID byte, and publishes buttons/sticks atomically.
// It replaces the two free-running per-pad controllers feeding p1/p2 in the top level.
// PARAMETERS
// POLL_CYCLES  337_500  clk cycles per poll slot (one pad per slot; 21.6 MHz -> 64 Hz/slot)
// SEL_SETUP    2_700    cycles between sel_n fall and first byte_start_o
// BYTE_GAP     1_350    idle cycles between byte_done_i and the next byte_start_o
// TIMEOUT      21_600   max cycles from byte_start_o to byte_done_i before abort
// PORTS
// clk            in   1   system clock
// I_RSTn         in   1   asynchronous active-low reset
// enable_i       in   1   1: run poll slots; 0: finish current transaction, then stay idle
// byte_start_o   out  1   one-cycle pulse: engine sends byte_tx_o
// byte_tx_o      out  8   command byte, stable from byte_start_o until byte_done_i
// byte_done_i    in   1   one-cycle pulse: byte_rx_i valid this cycle
// byte_rx_i      in   8   byte received from the selected pad
// sel_n_o        out  2   per-pad select, active low; at most one bit low
// pad0_btn_o     out  16  pad 0 buttons {byte4,byte3}, active low
// pad1_btn_o     out  16  pad 1 buttons, same layout
// pad0_ana_o     out  32  pad 0 sticks {byte8,byte7,byte6,byte5}
// pad1_ana_o     out  32  pad 1 sticks, same layout
// present_o      out  2   per-pad: 1 = last transaction valid
// update_o       out  1   one-cycle pulse when a pad's outputs were rewritten
// update_pad_o   out  1   pad index rewritten on update_o
// BEHAVIOUR
// - Reset: sel_n_o=2'b11, byte_start_o=0, byte_tx_o=0, btn=16'hFFFF, ana=32'h80808080,
//   present_o=0, update_o=0, update_pad_o=0, slot counter=0, next pad=0, FSM=IDLE.
// - Slot counter: counts 0..POLL_CYCLES-1, wraps; on wrap with enable_i=1 and FSM=IDLE start
//   a transaction on next pad, then toggle next pad. Wrap while busy: slot skipped, pad not toggled.
// - FSM: IDLE -> SETUP (sel_n low, SEL_SETUP cycles) -> XFER (pulse start, wait done) ->
//   GAP (BYTE_GAP cycles) -> XFER ... -> COMMIT (1 cycle) -> DESEL (sel_n high, BYTE_GAP) -> IDLE.
// - Command bytes by index k: 0:8'h01, 1:8'h42, >=2:8'h00.
// - Length: at k=1 done, N=byte_rx_i[3:0] clamped to 1..3 (0 -> 1); total bytes = 3+2N (5,7,9).
// - Rx bytes captured into a shadow buffer; outputs untouched until COMMIT.
// - Validity: byte2 must equal 8'h5A and byte1[7:4] in {4'h4,4'h5,4'h7}; else invalid.
// - COMMIT valid: btn <= shadow, ana <= shadow bytes 5..8 if N==3 else 32'h80808080,
//   present=1. Invalid: btn=16'hFFFF, ana=32'h80808080, present=0. update_o pulses either way.
// - Timeout: no byte_done_i within TIMEOUT cycles of start -> skip remaining bytes, COMMIT as
//   invalid. Late byte_done_i outside XFER is ignored.
// - byte_done_i in the same cycle as byte_start_o is ignored (engine latency >=1).
// - enable_i low: current transaction completes normally; no new slot starts.
// - Async reset mid-transaction: all state to reset values immediately; sel_n_o high at once.
// TESTING
// - Digital pad0 reply FF,41,5A,FE,7F -> 5 bytes sent 01,42,00,00,00; pad0_btn_o=16'h7FFE,
//   ana=32'h80808080, present_o[0]=1, update_o with update_pad_o=0.
// - Analog pad1 reply FF,73,5A,FF,FF,10,20,30,40 -> 9 bytes; pad1_ana_o=32'h40302010.
// - Byte2=8'hFF on pad0 -> present_o[0]=0, pad0_btn_o=16'hFFFF, pad1 outputs untouched.
// - Engine stalls after byte 3 -> abort at TIMEOUT, sel_n_o=11 after DESEL, present=0.
// - Two slots: sel_n_o alternates 2'b10 then 2'b01, never 2'b00; SEL_SETUP/BYTE_GAP exact.
// - I_RSTn low during byte 4 -> all outputs to reset values same cycle; clean restart on pad 0.

Source files
------------

// File: rtl/ps_pad_poll_scheduler.sv
// Two-pad DualShock poll sequencer over one shared full-duplex SPI byte engine.
// Latency: one slot per POLL_CYCLES; outputs change only in COMMIT, update_o visible the cycle after.
// Backpressure: waits on byte_done_i per byte (bounded by TIMEOUT); slots arriving while busy are skipped.
module ps_pad_poll_scheduler #(
  parameter int unsigned POLL_CYCLES = 337_500,
  parameter int unsigned SEL_SETUP   = 2_700,
  parameter int unsigned BYTE_GAP    = 1_350,
  parameter int unsigned TIMEOUT     = 21_600
) (
  input  logic        clk,
  input  logic        I_RSTn,
  input  logic        enable_i,
  output logic        byte_start_o,
  output logic [7:0]  byte_tx_o,
  input  logic        byte_done_i,
  input  logic [7:0]  byte_rx_i,
  output logic [1:0]  sel_n_o,
  output logic [15:0] pad0_btn_o,
  output logic [15:0] pad1_btn_o,
  output logic [31:0] pad0_ana_o,
  output logic [31:0] pad1_ana_o,
  output logic [1:0]  present_o,
  output logic        update_o,
  output logic        update_pad_o
);

  localparam int unsigned T_MAX1 = (SEL_SETUP > BYTE_GAP) ? SEL_SETUP : BYTE_GAP;
  localparam int unsigned T_MAX  = (TIMEOUT > T_MAX1) ? TIMEOUT : T_MAX1;
  localparam int TW = $clog2(T_MAX + 1);
  localparam int SW = $clog2(POLL_CYCLES);

  localparam logic [31:0] ANA_IDLE = 32'h80808080;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_GAP,
    S_COMMIT,
    S_DESEL
  } state_t;

  state_t          state;
  logic [SW-1:0]   slot_cnt;
  logic            slot_wrap;
  logic [TW-1:0]   tmr;
  logic [3:0]      byte_idx;
  logic [1:0]      n_len;
  logic            cur_pad;
  logic            next_pad;
  logic            aborted;
  logic [8:0][7:0] shadow;

  logic            last_byte;
  logic            id_ok;
  logic            reply_ok;
  logic [15:0]     btn_new;
  logic [31:0]     ana_new;

  // Command byte for transfer index k: poll header then zero padding.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    if (idx == 4'd0)      return 8'h01;
    else if (idx == 4'd1) return 8'h42;
    else                  return 8'h00;
  endfunction

  // Reply length in halfwords from the low ID nibble, clamped to 1..3.
  function automatic logic [1:0] len_decode(input logic [3:0] id_lo);
    if (id_lo == 4'd0)      return 2'd1;
    else if (id_lo > 4'd3)  return 2'd3;
    else                    return id_lo[1:0];
  endfunction

  assign slot_wrap = (slot_cnt == SW'(POLL_CYCLES - 1));
  // Index 1 never matches: the last index is 2+2N >= 4, so the stale n_len there is harmless.
  assign last_byte = (byte_idx == ({1'b0, n_len, 1'b0} + 4'd2));
  assign id_ok     = (shadow[1][7:4] == 4'h4) || (shadow[1][7:4] == 4'h5) ||
                     (shadow[1][7:4] == 4'h7);
  assign reply_ok  = !aborted && (shadow[2] == 8'h5A) && id_ok;
  assign btn_new   = reply_ok ? {shadow[4], shadow[3]} : 16'hFFFF;
  assign ana_new   = (reply_ok && (n_len == 2'd3)) ?
                     {shadow[8], shadow[7], shadow[6], shadow[5]} : ANA_IDLE;

  // Free-running poll slot counter.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      slot_cnt <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // Transaction sequencer: select, byte handshakes, shadow capture, atomic publish.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state        <= S_IDLE;
      tmr          <= '0;
      byte_idx     <= '0;
      n_len        <= 2'd1;
      cur_pad      <= 1'b0;
      next_pad     <= 1'b0;
      aborted      <= 1'b0;
      shadow       <= '0;
      sel_n_o      <= 2'b11;
      byte_start_o <= 1'b0;
      byte_tx_o    <= 8'h00;
      pad0_btn_o   <= 16'hFFFF;
      pad1_btn_o   <= 16'hFFFF;
      pad0_ana_o   <= ANA_IDLE;
      pad1_ana_o   <= ANA_IDLE;
      present_o    <= 2'b00;
      update_o     <= 1'b0;
      update_pad_o <= 1'b0;
    end else begin
      byte_start_o <= 1'b0;
      update_o     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (slot_wrap && enable_i) begin
            state    <= S_SETUP;
            cur_pad  <= next_pad;
            next_pad <= ~next_pad;
            sel_n_o  <= next_pad ? 2'b01 : 2'b10;
            tmr      <= '0;
            byte_idx <= '0;
            n_len    <= 2'd1;
            aborted  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (tmr == TW'(SEL_SETUP - 1)) begin
            state        <= S_XFER;
            tmr          <= '0;
            byte_start_o <= 1'b1;
            byte_tx_o    <= cmd_byte(byte_idx);
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_XFER: begin
          // A done coinciding with our own start pulse cannot belong to this byte.
          if (byte_done_i && !byte_start_o) begin
            shadow[byte_idx] <= byte_rx_i;
            if (byte_idx == 4'd1) begin
              n_len <= len_decode(byte_rx_i[3:0]);
            end
            tmr <= '0;
            if (last_byte) begin
              state <= S_COMMIT;
            end else begin
              state    <= S_GAP;
              byte_idx <= byte_idx + 4'd1;
            end
          end else if (tmr == TW'(TIMEOUT)) begin
            aborted <= 1'b1;
            state   <= S_COMMIT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_GAP: begin
          if (tmr == TW'(BYTE_GAP - 1)) begin
            state        <= S_XFER;
            tmr          <= '0;
            byte_start_o <= 1'b1;
            byte_tx_o    <= cmd_byte(byte_idx);
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_COMMIT: begin
          if (cur_pad) begin
            pad1_btn_o   <= btn_new;
            pad1_ana_o   <= ana_new;
            present_o[1] <= reply_ok;
          end else begin
            pad0_btn_o   <= btn_new;
            pad0_ana_o   <= ana_new;
            present_o[0] <= reply_ok;
          end
          update_o     <= 1'b1;
          update_pad_o <= cur_pad;
          sel_n_o      <= 2'b11;
          tmr          <= '0;
          state        <= S_DESEL;
        end
        S_DESEL: begin
          if (tmr == TW'(BYTE_GAP - 1)) begin
            state <= S_IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          sel_n_o <= 2'b11;
        end
      endcase
    end
  end

endmodule
